// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions used by the hazard controller: FSM state
// encoding, register-index width and a small register-compare helper.
package hazard_ctrl_pkg;

    // Architectural register index width (32 GPRs).
    localparam int REG_IDX_W = 5;

    // Width of the load-use bubble counter; holds LD_STALL_CYC-1 (max 6).
    localparam int LD_CNT_W = 3;

    // Hazard FSM states; encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MCWAIT  = 2'd2
    } hz_state_e;

    // True when two register indices name the same register.
    function automatic logic reg_match(input logic [REG_IDX_W-1:0] a,
                                       input logic [REG_IDX_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Pure combinational load-use hazard compare between the load in EX and
// the source operands of the instruction in ID. Register 0 never hazards.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                 idex_memread_i,
    input  logic [REG_IDX_W-1:0] idex_rt_i,
    input  logic [REG_IDX_W-1:0] ifid_rs_i,
    input  logic [REG_IDX_W-1:0] ifid_rt_i,
    input  logic                 ifid_uses_rt_i,
    output logic                 lu_o
);

    logic rs_hit;
    logic rt_hit;
    logic dst_nonzero;

    // Operand compares; rt only matters when the ID instruction reads it.
    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
    always_comb begin
        dst_nonzero = (idex_rt_i != '0);
        rs_hit      = reg_match(idex_rt_i, ifid_rs_i);
        rt_hit      = ifid_uses_rt_i & reg_match(idex_rt_i, ifid_rt_i);
        lu_o        = idex_memread_i & dst_nonzero & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: inserts load-use bubbles, freezes the pipe
// while a multi-cycle unit is busy, flushes on taken branches, counts
// stalled cycles and flags multi-cycle timeouts.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LD_STALL_CYC = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 16
)
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 idex_memread_i,
    input  logic [REG_IDX_W-1:0] idex_rt_i,
    input  logic [REG_IDX_W-1:0] ifid_rs_i,
    input  logic [REG_IDX_W-1:0] ifid_rt_i,
    input  logic                 ifid_uses_rt_i,
    input  logic                 branch_taken_i,
    input  logic                 mc_start_i,
    input  logic                 mc_done_i,
    output logic                 pc_write_o,
    output logic                 ifid_write_o,
    output logic                 idex_write_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 exmem_flush_o,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic                 err_o
);

    // Timeout counter only needs to reach MC_TIMEOUT-1.
    localparam int TMO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(MC_TIMEOUT - 1);
    localparam logic [LD_CNT_W-1:0] LD_LOAD  = LD_CNT_W'(LD_STALL_CYC - 1);

    hz_state_e             state_q, state_d;
    logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic lu;
    logic pc_write, ifid_write, idex_write;
    logic ifid_flush, idex_flush, exmem_flush;

    hazard_detect u_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .lu_o           (lu)
    );

    // Next-state logic and Mealy pipe controls; defaults let the pipe run.
    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken_i) begin
                    // Taken branch squashes the wrong-path instructions and
                    // wins over any hazard raised by them.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (LD_STALL_CYC > 1) begin
                        state_d  = ST_LDSTALL;
                        ld_cnt_d = LD_LOAD;
                    end
                end else if (mc_start_i) begin
                    state_d = ST_MCWAIT;
                    tmo_d   = '0;
                end
            end

            ST_LDSTALL: begin
                if (branch_taken_i) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = ST_RUN;
                    ld_cnt_d   = '0;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    ld_cnt_d   = ld_cnt_q - LD_CNT_W'(1);
                    if (ld_cnt_q <= LD_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_MCWAIT: begin
                if (mc_done_i) begin
                    // Result is available now, so the pipe advances this cycle.
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers; reset abandons any stall in progress.
    // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            ld_cnt_q    <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While reset is held the pipe is frozen and fully flushed.
    always_comb begin
        pc_write_o    = rst_i ? 1'b0 : pc_write;
        ifid_write_o  = rst_i ? 1'b0 : ifid_write;
        idex_write_o  = rst_i ? 1'b0 : idex_write;
        ifid_flush_o  = rst_i ? 1'b1 : ifid_flush;
        idex_flush_o  = rst_i ? 1'b1 : idex_flush;
        exmem_flush_o = rst_i ? 1'b1 : exmem_flush;
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Instance a uses default parameters;
// instance b uses LD_STALL_CYC=3, MC_TIMEOUT=4, CNT_W=3 to exercise the
// LDSTALL state, the timeout and counter saturation. Both share stimulus.
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       idex_memread_i;
    logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
    logic       ifid_uses_rt_i, branch_taken_i, mc_start_i, mc_done_i;

    logic        a_pc_w, a_ifid_w, a_idex_w, a_ifid_f, a_idex_f, a_exmem_f, a_err;
    logic [1:0]  a_state;
    logic [15:0] a_stall;
    logic        b_pc_w, b_ifid_w, b_idex_w, b_ifid_f, b_idex_f, b_exmem_f, b_err;
    logic [1:0]  b_state;
    logic [2:0]  b_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl dut_a (
        .clk_i (clk_i), .rst_i (rst_i),
        .idex_memread_i (idex_memread_i), .idex_rt_i (idex_rt_i),
        .ifid_rs_i (ifid_rs_i), .ifid_rt_i (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i), .branch_taken_i (branch_taken_i),
        .mc_start_i (mc_start_i), .mc_done_i (mc_done_i),
        .pc_write_o (a_pc_w), .ifid_write_o (a_ifid_w), .idex_write_o (a_idex_w),
        .ifid_flush_o (a_ifid_f), .idex_flush_o (a_idex_f), .exmem_flush_o (a_exmem_f),
        .state_o (a_state), .stall_cnt_o (a_stall), .err_o (a_err)
    );

    hazard_ctrl #(.LD_STALL_CYC(3), .MC_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk_i (clk_i), .rst_i (rst_i),
        .idex_memread_i (idex_memread_i), .idex_rt_i (idex_rt_i),
        .ifid_rs_i (ifid_rs_i), .ifid_rt_i (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i), .branch_taken_i (branch_taken_i),
        .mc_start_i (mc_start_i), .mc_done_i (mc_done_i),
        .pc_write_o (b_pc_w), .ifid_write_o (b_ifid_w), .idex_write_o (b_idex_w),
        .ifid_flush_o (b_ifid_f), .idex_flush_o (b_idex_f), .exmem_flush_o (b_exmem_f),
        .state_o (b_state), .stall_cnt_o (b_stall), .err_o (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        idex_memread_i = 1'b0;
        idex_rt_i      = '0;
        ifid_rs_i      = '0;
        ifid_rt_i      = '0;
        ifid_uses_rt_i = 1'b0;
        branch_taken_i = 1'b0;
        mc_start_i     = 1'b0;
        mc_done_i      = 1'b0;
    endtask

    task automatic load_use_r8();
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd8;
        ifid_rs_i      = 5'd8;
    endtask

    // Watchdog: the directed sequence is short; never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_i = 1'b1;
        #3;
        // Reset state and reset output override
        check("rst_pc_w",     32'(a_pc_w),    0);
        check("rst_ifid_w",   32'(a_ifid_w),  0);
        check("rst_idex_w",   32'(a_idex_w),  0);
        check("rst_ifid_f",   32'(a_ifid_f),  1);
        check("rst_idex_f",   32'(a_idex_f),  1);
        check("rst_exmem_f",  32'(a_exmem_f), 1);
        check("rst_state",    32'(a_state),   0);
        check("rst_stall",    32'(a_stall),   0);
        check("rst_err",      32'(a_err),     0);
        tick();
        rst_i = 1'b0;
        #1;
        check("run_pc_w",     32'(a_pc_w),    1);
        check("run_idex_w",   32'(a_idex_w),  1);
        check("run_ifid_f",   32'(a_ifid_f),  0);
        check("run_exmem_f",  32'(a_exmem_f), 0);

        // Load-use r8, single bubble on a, three bubbles on b
        load_use_r8();
        #1;
        check("lu_a_pc_w",    32'(a_pc_w),    0);
        check("lu_a_ifid_w",  32'(a_ifid_w),  0);
        check("lu_a_idex_f",  32'(a_idex_f),  1);
        check("lu_a_idex_w",  32'(a_idex_w),  1);
        check("lu_b_pc_w",    32'(b_pc_w),    0);
        tick();
        idle();
        #1;
        check("lu_a_state",   32'(a_state),   0);
        check("lu_a_stall",   32'(a_stall),   1);
        check("lu_a_pc_w2",   32'(a_pc_w),    1);
        check("lu_b_state1",  32'(b_state),   1);
        check("lu_b_pc_w1",   32'(b_pc_w),    0);
        check("lu_b_idex_f1", 32'(b_idex_f),  1);
        tick();
        check("lu_b_state2",  32'(b_state),   1);
        tick();
        check("lu_b_state3",  32'(b_state),   0);
        check("lu_b_stall",   32'(b_stall),   3);
        check("lu_b_pc_w3",   32'(b_pc_w),    1);

        // r0 never hazards; rt match without rt use does not hazard
        idex_memread_i = 1'b1;
        #1;
        check("r0_a_pc_w",    32'(a_pc_w),    1);
        check("r0_b_pc_w",    32'(b_pc_w),    1);
        idex_rt_i = 5'd9; ifid_rt_i = 5'd9; ifid_rs_i = 5'd1;
        #1;
        check("rt_nouse_pc_w", 32'(a_pc_w),   1);
        ifid_uses_rt_i = 1'b1;
        #1;
        check("rt_use_pc_w",  32'(a_pc_w),    0);
        idle();
        #1;

        // Branch wins over load-use in the same cycle
        load_use_r8();
        branch_taken_i = 1'b1;
        #1;
        check("br_ifid_f",    32'(a_ifid_f),  1);
        check("br_idex_f",    32'(a_idex_f),  1);
        check("br_a_pc_w",    32'(a_pc_w),    1);
        check("br_b_pc_w",    32'(b_pc_w),    1);
        tick();
        idle();
        #1;
        check("br_a_state",   32'(a_state),   0);
        check("br_b_state",   32'(b_state),   0);
        check("br_a_stall",   32'(a_stall),   1);

        // Branch during LDSTALL returns b to RUN at once
        load_use_r8();
        tick();
        idle();
        #1;
        check("ldbr_b_state", 32'(b_state),   1);
        check("ldbr_a_stall", 32'(a_stall),   2);
        branch_taken_i = 1'b1;
        #1;
        check("ldbr_b_ifid_f", 32'(b_ifid_f), 1);
        check("ldbr_b_idex_f", 32'(b_idex_f), 1);
        check("ldbr_b_pc_w",  32'(b_pc_w),    1);
        tick();
        branch_taken_i = 1'b0;
        #1;
        check("ldbr_b_state2", 32'(b_state),  0);
        check("ldbr_b_stall", 32'(b_stall),   4);

        // Multi-cycle op: a waits 5 stalled cycles then sees mc_done;
        // b times out after 4 MCWAIT cycles and saturates its counter.
        mc_start_i = 1'b1;
        #1;
        check("mc0_a_pc_w",   32'(a_pc_w),    1);
        check("mc0_a_idex_w", 32'(a_idex_w),  1);
        check("mc0_a_exmem_f", 32'(a_exmem_f), 0);
        tick();
        mc_start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) branch_taken_i = 1'b1;
            #1;
            check($sformatf("mcw%0d_a_state", k),   32'(a_state),   2);
            check($sformatf("mcw%0d_a_idex_w", k),  32'(a_idex_w),  0);
            check($sformatf("mcw%0d_a_exmem_f", k), 32'(a_exmem_f), 1);
            if (k == 2) check("mcw_br_ignored", 32'(a_ifid_f), 0);
            if (k == 3) begin
                check("tmo_b_state3", 32'(b_state), 2);
                check("tmo_b_err3",   32'(b_err),   0);
            end
            if (k == 4) begin
                check("tmo_b_state4", 32'(b_state), 0);
                check("tmo_b_err4",   32'(b_err),   1);
                check("sat_b_stall",  32'(b_stall), 7);
            end
            branch_taken_i = 1'b0;
            tick();
        end
        mc_done_i = 1'b1;
        #1;
        check("mcd_a_state",  32'(a_state),   2);
        check("mcd_a_pc_w",   32'(a_pc_w),    1);
        check("mcd_a_idex_w", 32'(a_idex_w),  1);
        check("mcd_a_exmem_f", 32'(a_exmem_f), 0);
        tick();
        mc_done_i = 1'b0;
        #1;
        check("mcd_a_state2", 32'(a_state),   0);
        check("mcd_a_stall",  32'(a_stall),   7);
        check("done_ign_b_state", 32'(b_state), 0);
        check("err_held_b",   32'(b_err),     1);

        // Asynchronous reset in the middle of MCWAIT
        mc_start_i = 1'b1;
        tick();
        mc_start_i = 1'b0;
        tick();
        check("mcr_a_state",  32'(a_state),   2);
        check("mcr_b_err",    32'(b_err),     1);
        #2;
        rst_i = 1'b1;
        #1;
        check("mcr_rst_state",   32'(a_state),   0);
        check("mcr_rst_ifid_f",  32'(a_ifid_f),  1);
        check("mcr_rst_idex_f",  32'(a_idex_f),  1);
        check("mcr_rst_exmem_f", 32'(a_exmem_f), 1);
        check("mcr_rst_pc_w",    32'(a_pc_w),    0);
        check("mcr_rst_stall",   32'(a_stall),   0);
        check("mcr_rst_b_err",   32'(b_err),     0);
        tick();
        rst_i = 1'b0;
        #1;
        check("mcr_rel_state",   32'(a_state),   0);
        check("mcr_rel_pc_w",    32'(a_pc_w),    1);
        check("mcr_rel_idex_w",  32'(a_idex_w),  1);
        check("mcr_rel_exmem_f", 32'(a_exmem_f), 0);
        tick();
        tick();
        check("mcr_post_state",  32'(a_state),   0);
        check("mcr_post_stall",  32'(a_stall),   0);
        check("mcr_post_b_state", 32'(b_state),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LD_STALL_CYC, default 1, range 1..7; bubbles inserted per load-use hazard.
REQ-002 Parameter MC_TIMEOUT, default 64; max cycles to wait for mc_done_i before error.
REQ-003 Parameter CNT_W, default 16; stall counter width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 idex_memread_i  in  1  instruction in EX is a load.
REQ-007 idex_rt_i  in  5  load destination register in EX.
REQ-008 ifid_rs_i, ifid_rt_i  in  5 each  source registers of instruction in ID.
REQ-009 ifid_uses_rt_i  in  1  ID instruction reads rt.
REQ-010 branch_taken_i  in  1  taken branch/jump resolved in EX this cycle.
REQ-011 mc_start_i  in  1  multi-cycle op (mul/div) entering EX this cycle.
REQ-012 mc_done_i  in  1  multi-cycle unit result valid, 1-cycle pulse.
REQ-013 pc_write_o, ifid_write_o, idex_write_o  out  1 each  write enables for PC and IF/ID, ID/EX pipe registers.
REQ-014 ifid_flush_o, idex_flush_o, exmem_flush_o  out  1 each  synchronous-clear requests to the pipe registers.
REQ-015 state_o  out  2  current FSM state: RUN=0, LDSTALL=1, MCWAIT=2.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of stalled cycles.
REQ-017 err_o  out  1  sticky multi-cycle timeout flag.

Function
REQ-018 Load-use hazard (LU) SHALL be idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
REQ-019 Outputs SHALL be combinational from state and inputs (Mealy); default all *_write_o=1, all *_flush_o=0.
REQ-020 RUN, branch_taken_i=1: ifid_flush_o=1, idex_flush_o=1, writes stay 1; state remains RUN; branch overrides LU and mc_start_i that cycle.
REQ-021 RUN, LU, no branch: pc_write_o=0, ifid_write_o=0, idex_flush_o=1; if LD_STALL_CYC>1, go LDSTALL with remaining counter LD_STALL_CYC-1, else stay RUN.
REQ-022 LDSTALL: same outputs as REQ-021; decrement counter each cycle; return to RUN when counter reaches 0 (after the last bubble cycle); branch_taken_i in LDSTALL applies REQ-020 and returns to RUN immediately.
REQ-023 RUN, mc_start_i, no branch, no LU: go MCWAIT next cycle; timeout counter loaded 0; current-cycle outputs per default.
REQ-024 MCWAIT: pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_flush_o=1; branch_taken_i ignored.
REQ-025 MCWAIT, mc_done_i=1: outputs return to default in that same cycle; state RUN next cycle.
REQ-026 MCWAIT, timeout counter reaches MC_TIMEOUT-1 without mc_done_i: set err_o, return to RUN next cycle.
REQ-027 mc_done_i outside MCWAIT SHALL be ignored.
REQ-028 stall_cnt_o SHALL increment every cycle pc_write_o=0, saturating at all ones.
REQ-029 err_o SHALL remain set until reset.

Reset
REQ-030 rst_i asserted SHALL asynchronously set state RUN, all counters 0, err_o 0, stall_cnt_o 0.
REQ-031 While rst_i high: all *_write_o=0 and all *_flush_o=1, overriding REQ-019..026.
REQ-032 Reset mid-LDSTALL or mid-MCWAIT SHALL abandon the stall with no residual effect after release.

Structure
REQ-033 State encoding (RUN/LDSTALL/MCWAIT) and register-index width (5) SHALL live in the shared CPU package.
REQ-034 One sub-module, hazard_detect (pure combinational LU compare, REQ-018), SHALL be instantiated; FSM and counters remain in hazard_ctrl.

Verification
REQ-035 LU: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8, LD_STALL_CYC=1 -> one cycle pc_write_o=0, ifid_write_o=0, idex_flush_o=1; stall_cnt_o=1.
REQ-036 idex_rt_i=0 with ifid_rs_i=0, memread=1 -> no stall; ifid_uses_rt_i=0 with rt match only -> no stall.
REQ-037 branch_taken_i and LU same cycle -> ifid_flush_o=idex_flush_o=1, pc_write_o=1, state stays RUN.
REQ-038 mc_start_i, mc_done_i 5 cycles later -> state MCWAIT 5 cycles, idex_write_o=0, exmem_flush_o=1, stall_cnt_o=5, then RUN.
REQ-039 MC_TIMEOUT=4, no mc_done_i -> err_o=1 after 4 MCWAIT cycles, RUN next; err_o held until rst_i.
REQ-040 rst_i pulsed mid-MCWAIT, asynchronously -> state_o=0, all flushes 1 during reset, defaults after release.
